// File: rtl/jam.sv
`default_nettype none
// ============================================================================
//  Module   : jam
//  Purpose  : Job-assignment minimiser. Walks all 8! worker/job permutations
//             in lexicographic order, summing costs read from an external ROM,
//             and reports the minimum total and how many permutations reach it.
//  Revision : 1.0  initial release
// ============================================================================
module jam (
    input  logic       CLK,
    input  logic       RST,
    output logic [2:0] W,
    output logic [2:0] J,
    input  logic [6:0] Cost,
    output logic [3:0] MatchCount,
    output logic [9:0] MinCost,
    output logic       Valid
);

    localparam logic [1:0]      c_CALC     = 2'd0;
    localparam logic [1:0]      c_CMP      = 2'd1;
    localparam logic [1:0]      c_NEXT     = 2'd2;
    localparam logic [1:0]      c_DONE     = 2'd3;
    localparam logic [9:0]      c_MIN_INIT = 10'h3FF;
    localparam logic [3:0]      c_CNT_MAX  = 4'd15;
    localparam logic [2:0]      c_LAST_W   = 3'd7;
    localparam logic [7:0][2:0] c_IDENTITY = {3'd7, 3'd6, 3'd5, 3'd4,
                                              3'd3, 3'd2, 3'd1, 3'd0};

    logic [1:0]      state_q, state_d;
    logic [2:0]      widx_q, widx_d;
    logic [2:0]      jidx_q, jidx_d;
    logic [9:0]      sum_q, sum_d;
    logic [9:0]      min_q, min_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0][2:0] perm_q, perm_d;

    logic [2:0]      pivot;
    logic [2:0]      succ;
    logic            has_next;
    logic [7:0][2:0] swapped;
    logic [7:0][2:0] next_perm;

    // Lexicographic successor of perm_q, computed in a single cycle.
    always_comb begin
        pivot     = 3'd0;
        succ      = 3'd0;
        has_next  = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (perm_q[i] < perm_q[i+1]) begin
                pivot    = 3'(i);
                has_next = 1'b1;
            end
        end
        // The suffix is descending, so the rightmost larger entry is the smallest one.
        for (int k = 1; k < 8; k++) begin
            if ((3'(k) > pivot) && (perm_q[k] > perm_q[pivot])) begin
                succ = 3'(k);
            end
        end
        swapped        = perm_q;
        swapped[pivot] = perm_q[succ];
        swapped[succ]  = perm_q[pivot];
        next_perm      = swapped;
        for (int m = 1; m < 8; m++) begin
            if (3'(m) > pivot) begin
                next_perm[m] = swapped[3'(4'(pivot) + 4'd8 - 4'(m))];
            end
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= c_CALC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_CALC: begin
                if (widx_q == c_LAST_W) begin
                    state_d = c_CMP;
                end
            end
            c_CMP: begin
                state_d = has_next ? c_NEXT : c_DONE;
            end
            c_NEXT:  state_d = c_CALC;
            c_DONE:  state_d = c_DONE;
            default: state_d = c_CALC;
        endcase
    end

    // Output decode
    always_comb begin
        Valid = (state_q == c_DONE);
    end

    // Datapath next values
    always_comb begin
        widx_d = widx_q;
        jidx_d = jidx_q;
        sum_d  = sum_q;
        min_d  = min_q;
        cnt_d  = cnt_q;
        perm_d = perm_q;
        case (state_q)
            c_CALC: begin
                sum_d  = sum_q + {3'b000, Cost};
                // Index wraps 7 -> 0, leaving the bus parked on worker 0.
                widx_d = widx_q + 3'd1;
                jidx_d = perm_q[widx_q + 3'd1];
            end
            c_CMP: begin
                if (sum_q < min_q) begin
                    min_d = sum_q;
                    cnt_d = 4'd1;
                end else if ((sum_q == min_q) && (cnt_q != c_CNT_MAX)) begin
                    cnt_d = cnt_q + 4'd1;
                end
                sum_d = 10'd0;
            end
            c_NEXT: begin
                perm_d = next_perm;
                jidx_d = next_perm[0];
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            widx_q <= 3'd0;
            jidx_q <= 3'd0;
            sum_q  <= 10'd0;
            min_q  <= c_MIN_INIT;
            cnt_q  <= 4'd0;
            perm_q <= c_IDENTITY;
        end else begin
            widx_q <= widx_d;
            jidx_q <= jidx_d;
            sum_q  <= sum_d;
            min_q  <= min_d;
            cnt_q  <= cnt_d;
            perm_q <= perm_d;
        end
    end

    assign W          = widx_q;
    assign J          = jidx_q;
    assign MinCost    = min_q;
    assign MatchCount = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_jam.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jam
//  Purpose  : Directed and random cost tables for jam, with a queue of
//             expected results compared when Valid rises.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jam;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [2:0] W;
    logic [2:0] J;
    logic [6:0] Cost;
    logic [3:0] MatchCount;
    logic [9:0] MinCost;
    logic       Valid;

    logic [6:0] rom [8][8];
    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        int    min_cost;
        int    match_cnt;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    assign Cost = rom[W][J];

    jam dut (
        .CLK        (CLK),
        .RST        (RST),
        .W          (W),
        .J          (J),
        .Cost       (Cost),
        .MatchCount (MatchCount),
        .MinCost    (MinCost),
        .Valid      (Valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_W"}, W, 0);
        check({tag, "_J"}, J, 0);
        check({tag, "_valid"}, Valid, 0);
        check({tag, "_mincost"}, MinCost, 10'h3FF);
        check({tag, "_count"}, MatchCount, 0);
    endtask

    task automatic apply_reset(input string tag);
        RST = 1'b1;
        tick();
        check_reset_state(tag);
        tick();
        RST = 1'b0;
    endtask

    // Software reference: min and saturated count over every permutation.
    task automatic push_golden(input string tag);
        int p[8];
        int best, cnt, tot, piv, k, t, lo, hi;
        bit more;
        exp_t e;
        best = 1023;
        cnt  = 0;
        more = 1'b1;
        for (int a = 0; a < 8; a++) p[a] = a;
        while (more) begin
            tot = 0;
            for (int w = 0; w < 8; w++) tot += int'(rom[w][p[w]]);
            if (tot < best) begin
                best = tot;
                cnt  = 1;
            end else if (tot == best && cnt < 15) begin
                cnt++;
            end
            piv = -1;
            for (int a = 0; a < 7; a++) if (p[a] < p[a+1]) piv = a;
            if (piv < 0) begin
                more = 1'b0;
            end else begin
                k = piv + 1;
                for (int a = piv + 1; a < 8; a++) if (p[a] > p[piv]) k = a;
                t = p[piv]; p[piv] = p[k]; p[k] = t;
                lo = piv + 1;
                hi = 7;
                while (lo < hi) begin
                    t = p[lo]; p[lo] = p[hi]; p[hi] = t;
                    lo++;
                    hi--;
                end
            end
        end
        e.tag       = tag;
        e.min_cost  = best;
        e.match_cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic push_const(input string tag, input int mc, input int cnt);
        exp_t e;
        e.tag       = tag;
        e.min_cost  = mc;
        e.match_cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic wait_and_score();
        int   cyc;
        exp_t e;
        logic [2:0] w_hold;
        logic [2:0] j_hold;
        cyc = 0;
        while (!Valid && cyc < 600000) begin
            tick();
            cyc++;
        end
        e = sb.pop_front();
        check({e.tag, "_valid_rise"}, Valid, 1);
        check({e.tag, "_latency_le_450000"}, (cyc <= 450000), 1);
        check({e.tag, "_mincost"}, MinCost, e.min_cost);
        check({e.tag, "_count"}, MatchCount, e.match_cnt);
        w_hold = W;
        j_hold = J;
        for (int n = 0; n < 10; n++) begin
            tick();
            check({e.tag, "_hold_valid"}, Valid, 1);
            check({e.tag, "_hold_mincost"}, MinCost, e.min_cost);
            check({e.tag, "_hold_count"}, MatchCount, e.match_cnt);
            check({e.tag, "_hold_W"}, W, w_hold);
            check({e.tag, "_hold_J"}, J, j_hold);
        end
    endtask

    initial begin
        // Diagonal table, interrupted by a reset at cycle 1000.
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                rom[w][j] = (w == j) ? 7'd0 : 7'd100;
        push_const("diag", 0, 1);
        apply_reset("rst_initial");
        repeat (1000) tick();
        check("midrun_valid", Valid, 0);
        check("midrun_mincost", MinCost, 0);
        check("midrun_count", MatchCount, 1);
        RST = 1'b1;
        tick();
        check_reset_state("rst_mid_1");
        tick();
        check_reset_state("rst_mid_2");
        RST = 1'b0;
        wait_and_score();

        // Anti-diagonal: optimum is the final permutation.
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                rom[w][j] = (j == 7 - w) ? 7'd0 : 7'd50;
        push_const("anti", 0, 1);
        apply_reset("rst_anti");
        wait_and_score();

        // Two optimal assignments (workers 0/1 may swap jobs 0/1).
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                rom[w][j] = ((w == j && w >= 2) || (w < 2 && j < 2)) ? 7'd1 : 7'd100;
        push_const("two_opt", 8, 2);
        apply_reset("rst_two");
        wait_and_score();

        // Uniform maximum cost: widest sum, saturated count.
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                rom[w][j] = 7'd127;
        push_const("uniform", 1016, 15);
        apply_reset("rst_uniform");
        wait_and_score();

        // Random table against the software reference.
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                rom[w][j] = 7'($urandom_range(0, 127));
        push_golden("random");
        apply_reset("rst_random");
        wait_and_score();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jam.md
# jam

Job-assignment minimiser (JAM). It pairs 8 workers with 8 jobs, one job per worker, and reads each pairing's cost from an external combinational cost ROM through its W/J address ports. It exhaustively enumerates all 8! = 40320 assignments and reports the minimum total cost and how many assignments reach it. It is a standalone compute block that sits next to the cost ROM and asserts Valid when the answer is ready.

## Interface
- No parameters. Sizes are fixed: 8 workers, 8 jobs, 7-bit costs.
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- W  output  3  worker index; ROM address high part; registered.
- J  output  3  job index; ROM address low part; registered.
- Cost  input  7  ROM data, equal to cost[W][J]; combinational from W/J within the same cycle.
- MatchCount  output  4  number of assignments whose total equals MinCost; saturates at 15.
- MinCost  output  10  minimum total cost, range 0..1016.
- Valid  output  1  result ready.

## Operation
- An assignment is a permutation p, where worker w takes job p[w].
- total(p) = sum over w of cost[w][p[w]].
- Enumeration order:
  - Lexicographic, starting at identity (0,1,…,7) and ending at (7,6,…,0).
  - Every permutation is visited exactly once.
  - Next permutation uses the standard algorithm: find the largest i with p[i] < p[i+1]; swap p[i] with the smallest p[k] > p[i] for k > i; reverse p[i+1..7].
- States:
  - CALC: 8 cycles. Drive W = 0..7 and J = p[W]. On each edge, sum += Cost; the sum is 10 bits wide and never overflows.
  - CMP: 1 cycle.
    - If sum < min: min = sum and count = 1.
    - If sum == min: count = count + 1, saturating at 15.
    - Otherwise: no change.
    - Then clear sum.
    - Go to DONE if p is (7,…,0), else go to NEXT.
  - NEXT: at most 2 cycles; compute the next permutation, then go to CALC.
  - DONE: Valid = 1. W, J, MinCost and MatchCount are frozen. Stay in DONE until RST.
- min is initialised to 1023, so the first permutation always replaces it.
- The MinCost and MatchCount outputs are driven directly by the min and count registers.
- The ROM is read-only and holds data only. The block never assumes ROM contents are stable across a reset.

## Timing
- Reset values: W=0, J=0, Valid=0, MinCost=10'h3FF, MatchCount=0, p=identity, sum=0, state=CALC.
- Enumeration starts on the first edge with RST=0.
- Cost is sampled on the same edge that changes W/J; W/J must be stable for the whole cycle before that edge.
- Each permutation takes at most 11 cycles.
- Valid must rise no later than 450000 cycles after RST deasserts; the bench timeout is 600000.
- Valid is high from the cycle after the last CMP. MinCost and MatchCount are final and stable whenever Valid=1.
- RST asserted mid-enumeration or in DONE:
  - Outputs return to their reset values at the next edge.
  - Enumeration restarts from identity; no partial state is kept.
- Ties with the current minimum count only once min is final. A lower sum always resets count to 1, discarding earlier ties.

## Test plan
- Diagonal table: cost[w][w]=0, all others 100 → MinCost=0, MatchCount=1.
- Anti-diagonal table: cost[w][7-w]=0, others 50 → MinCost=0, MatchCount=1. This checks that the final permutation is evaluated.
- Two optima: cost[w][w]=1 for w≥2, cost[0][1]=cost[1][0]=cost[0][0]=cost[1][1]=1, others 100 → MinCost=8, MatchCount=2.
- Uniform table: all cost=127 → MinCost=1016, MatchCount=15 (saturated). Also checks that the 10-bit sum does not overflow.
- Reset mid-run: assert RST for 2 cycles at cycle 1000 of the diagonal test, then release → W=J=Valid=0 during reset; final MinCost=0, MatchCount=1.
- Random tables with software golden min/count (count ≤ 15) → values match at Valid; Valid cycle ≤ 450000; Valid stays high and outputs hold for 10 further cycles.
